// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder controller: streams operands one nibble per cycle through an
// external 4-bit adder, ripples the carry in a flop and assembles SUM/COUT/OVF.
module nibble_serial_adder_ctrl #(
    parameter int unsigned NIBBLES = 4,
    localparam int unsigned W = 4 * NIBBLES
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic         CIN,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [3:0]   ADD_A,
    output logic [3:0]   ADD_B,
    output logic         ADD_C0,
    input  logic [3:0]   ADD_S,
    input  logic         ADD_C4,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] SUM,
    output logic         COUT,
    output logic         OVF
);

    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [W-1:0]   res_q, res_d;
    logic           carry_q, carry_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;
    logic [W-1:0]   res_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        ADD_A   = '0;
        ADD_B   = '0;
        ADD_C0  = 1'b0;
        BUSY    = 1'b0;
        DONE    = 1'b0;
        // Shift-and-insert written without a slice so NIBBLES=1 (W=4) stays legal
        res_next = (res_q >> 4) | (W'(ADD_S) << (W - 4));

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    opa_d   = A;
                    opb_d   = B;
                    carry_d = CIN;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                BUSY    = 1'b1;
                ADD_A   = opa_q[3:0];
                ADD_B   = opb_q[3:0];
                ADD_C0  = carry_q;
                res_d   = res_next;
                carry_d = ADD_C4;
                opa_d   = opa_q >> 4;
                opb_d   = opb_q >> 4;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(NIBBLES - 1)) begin
                    sum_d   = res_next;
                    cout_d  = ADD_C4;
                    ovf_d   = (opa_q[3] == opb_q[3]) && (ADD_S[3] != opa_q[3]);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                DONE    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign SUM  = sum_q;
    assign COUT = cout_q;
    assign OVF  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl with a behavioural 4-bit adder
// closing the ADD_* loop.
module tb_nibble_serial_adder_ctrl;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic         CIN = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [3:0]   ADD_A, ADD_B, ADD_S;
    logic         ADD_C0, ADD_C4;
    logic         BUSY, DONE, COUT, OVF;
    logic [W-1:0] SUM;

    int unsigned  vectors = 0;
    int unsigned  miscompares = 0;
    logic [W+1:0] exp_q[$];
    logic [W-1:0] last_sum = '0;
    logic         last_cout = 1'b0;
    logic         last_ovf = 1'b0;

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .CLK(CLK), .RST(RST), .START(START), .CIN(CIN), .A(A), .B(B),
        .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_C0(ADD_C0), .ADD_S(ADD_S), .ADD_C4(ADD_C4),
        .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .COUT(COUT), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    assign {ADD_C4, ADD_S} = 5'(ADD_A) + 5'(ADD_B) + 5'(ADD_C0);

    // Returns {sum, cout, ovf}
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        logic [W:0] full;
        logic       ovf;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return {full[W-1:0], full[W], ovf};
    endfunction

    task automatic test_reset();
        RST = 1'b1;
        START = 1'b1;
        for (int i = 0; i < 2; i++) begin
            A = W'($urandom);
            B = W'($urandom);
            CIN = 1'($urandom);
            @(posedge CLK); #1;
            vectors++;
            if ({BUSY, DONE, SUM, COUT, OVF, ADD_A, ADD_B, ADD_C0} !== '0) begin
                miscompares++;
                $display("FAIL reset: busy=%b done=%b sum=%h cout=%b ovf=%b adda=%h addb=%h c0=%b required all 0",
                         BUSY, DONE, SUM, COUT, OVF, ADD_A, ADD_B, ADD_C0);
            end
        end
        RST = 1'b0;
        START = 1'b0;
        last_sum = '0;
        last_cout = 1'b0;
        last_ovf = 1'b0;
    endtask

    task automatic test_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input string name);
        logic [3:0]   na, nb;
        logic [4:0]   t;
        logic         c;
        logic [W+1:0] e;
        A = a;
        B = b;
        CIN = cin;
        START = 1'b1;
        exp_q.push_back(model(a, b, cin));
        c = cin;
        @(posedge CLK); #1;
        START = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        CIN = 1'($urandom);
        for (int i = 0; i < int'(N); i++) begin
            na = 4'(a >> (4 * i));
            nb = 4'(b >> (4 * i));
            vectors++;
            if ({BUSY, DONE, ADD_A, ADD_B, ADD_C0} !== {1'b1, 1'b0, na, nb, c}) begin
                miscompares++;
                $display("FAIL %s nibble%0d: busy=%b done=%b a=%h b=%h c0=%b required 1 0 %h %h %b",
                         name, i, BUSY, DONE, ADD_A, ADD_B, ADD_C0, na, nb, c);
            end
            vectors++;
            if ({SUM, COUT, OVF} !== {last_sum, last_cout, last_ovf}) begin
                miscompares++;
                $display("FAIL %s hold%0d: sum=%h cout=%b ovf=%b required %h %b %b",
                         name, i, SUM, COUT, OVF, last_sum, last_cout, last_ovf);
            end
            t = 5'(na) + 5'(nb) + 5'(c);
            c = t[4];
            @(posedge CLK); #1;
        end
        vectors++;
        if ({BUSY, DONE, ADD_A, ADD_B, ADD_C0} !== {1'b0, 1'b1, 9'b0}) begin
            miscompares++;
            $display("FAIL %s done_cycle: busy=%b done=%b a=%h b=%h c0=%b required 0 1 0 0 0",
                     name, BUSY, DONE, ADD_A, ADD_B, ADD_C0);
        end
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s scoreboard: queue empty, required one entry", name);
        end else begin
            e = exp_q.pop_front();
            if ({SUM, COUT, OVF} !== e) begin
                miscompares++;
                $display("FAIL %s result: sum=%h cout=%b ovf=%b required %h %b %b",
                         name, SUM, COUT, OVF, e[W+1:2], e[1], e[0]);
            end
            {last_sum, last_cout, last_ovf} = e;
        end
        @(posedge CLK); #1;
        vectors++;
        if ({BUSY, DONE} !== 2'b00) begin
            miscompares++;
            $display("FAIL %s idle_after: busy=%b done=%b required 0 0", name, BUSY, DONE);
        end
    endtask

    // START held high: accepts every N+2 edges with operands changing every cycle
    task automatic test_back_to_back();
        logic [W+1:0] e;
        int unsigned  ph;
        START = 1'b1;
        for (int k = 0; k < 3 * (int'(N) + 2); k++) begin
            ph = k % (N + 2);
            if (ph == 0) exp_q.push_back(model(A, B, CIN));
            @(posedge CLK); #1;
            vectors++;
            if ({BUSY, DONE} !== {(ph < N), (ph == N)}) begin
                miscompares++;
                $display("FAIL b2b edge%0d: busy=%b done=%b required %b %b",
                         k, BUSY, DONE, (ph < N), (ph == N));
            end
            if (ph == N) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b scoreboard: queue empty, required one entry");
                end else begin
                    e = exp_q.pop_front();
                    if ({SUM, COUT, OVF} !== e) begin
                        miscompares++;
                        $display("FAIL b2b result edge%0d: sum=%h cout=%b ovf=%b required %h %b %b",
                                 k, SUM, COUT, OVF, e[W+1:2], e[1], e[0]);
                    end
                    {last_sum, last_cout, last_ovf} = e;
                end
            end
            A = W'($urandom);
            B = W'($urandom);
            CIN = 1'($urandom);
        end
        START = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_abort();
        A = 16'hABCD;
        B = 16'h1357;
        CIN = 1'b1;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        vectors++;
        if ({BUSY, DONE, SUM, COUT, OVF, ADD_A, ADD_B, ADD_C0} !== '0) begin
            miscompares++;
            $display("FAIL abort: busy=%b done=%b sum=%h cout=%b ovf=%b a=%h b=%h c0=%b required all 0",
                     BUSY, DONE, SUM, COUT, OVF, ADD_A, ADD_B, ADD_C0);
        end
        last_sum = '0;
        last_cout = 1'b0;
        last_ovf = 1'b0;
        for (int i = 0; i < int'(N) + 2; i++) begin
            @(posedge CLK); #1;
            vectors++;
            if ({BUSY, DONE} !== 2'b00) begin
                miscompares++;
                $display("FAIL abort_quiet%0d: busy=%b done=%b required 0 0", i, BUSY, DONE);
            end
        end
        test_op(16'h2468, 16'h1111, 1'b0, "after_abort");
    endtask

    initial begin
        test_reset();
        test_op(16'h1234, 16'h4321, 1'b0, "basic");
        test_op(16'hFFFF, 16'h0001, 1'b0, "ripple1");
        test_op(16'h0000, 16'hFFFF, 1'b1, "ripple2");
        test_op(16'h7FFF, 16'h0001, 1'b0, "ovf_pos");
        test_op(16'h8000, 16'h8000, 1'b0, "ovf_neg");
        for (int i = 0; i < 4; i++)
            test_op(W'($urandom), W'($urandom), 1'($urandom), "random");
        test_back_to_back();
        test_abort();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
